// File: rtl/tick_period_monitor.sv
// Tick-pulse period monitor: measures spacing of divider ticks on clk_1ms, locks onto
// the expected period and flags early or missing ticks with sticky error bits and counters.
module tick_period_monitor #(
    parameter int EXP_PERIOD = 6,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_1ms,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             clear_fault,
    output logic             locked,
    output logic             fault,
    output logic             early_err,
    output logic             late_err,
    output logic [7:0]       period_last,
    output logic [CNT_W-1:0] tick_count,
    output logic [7:0]       missed_count
);
    // state   | meaning
    // IDLE    | waiting for the first tick event
    // ACQUIRE | counting consecutive in-tolerance periods
    // LOCKED  | period tracked; early/late ticks cause FAULT
    // FAULT   | error latched until clear_fault
    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, FAULT} state_t;

    localparam logic [7:0] P_LO     = 8'(EXP_PERIOD - TOL);
    localparam logic [7:0] P_HI     = 8'(EXP_PERIOD + TOL);
    localparam logic [7:0] DEADLINE = 8'(EXP_PERIOD + TOL - 1);
    localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);

    state_t     state;
    logic       tick_d;
    logic [7:0] cnt;
    logic [3:0] good_run;
    logic       ev;
    logic [7:0] period_meas;
    logic       in_tol;

    assign ev          = tick_in & ~tick_d;
    assign period_meas = (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;
    assign in_tol      = (period_meas >= P_LO) && (period_meas <= P_HI);
    assign locked      = (state == LOCKED);
    assign fault       = (state == FAULT);

    always_ff @(posedge clk_1ms) begin
        if (reset) begin
            state        <= IDLE;
            tick_d       <= 1'b1;
            cnt          <= 8'd0;
            good_run     <= 4'd0;
            early_err    <= 1'b0;
            late_err     <= 1'b0;
            period_last  <= 8'd0;
            tick_count   <= '0;
            missed_count <= 8'd0;
        end else begin
            tick_d <= tick_in;

            if (ev)
                cnt <= 8'd0;
            else if (cnt != 8'hFF)
                cnt <= cnt + 8'd1;

            if (ev)
                tick_count <= tick_count + CNT_W'(1);

            // The first event after IDLE has no valid preceding tick to measure against.
            if (ev && state != IDLE)
                period_last <= period_meas;

            unique case (state)
                IDLE: begin
                    if (ev) begin
                        state    <= ACQUIRE;
                        good_run <= 4'd0;
                    end
                end
                ACQUIRE: begin
                    if (ev) begin
                        if (in_tol) begin
                            good_run <= good_run + 4'd1;
                            if (good_run + 4'd1 == LOCK_N)
                                state <= LOCKED;
                        end else begin
                            good_run <= 4'd0;
                        end
                    end else if (cnt == 8'hFF) begin
                        state <= IDLE;
                    end
                end
                LOCKED: begin
                    if (ev) begin
                        if (period_meas < P_LO) begin
                            state     <= FAULT;
                            early_err <= 1'b1;
                        end
                    end else if (cnt == DEADLINE) begin
                        state    <= FAULT;
                        late_err <= 1'b1;
                        if (missed_count != 8'hFF)
                            missed_count <= missed_count + 8'd1;
                    end
                end
                FAULT: begin
                    if (clear_fault) begin
                        early_err <= 1'b0;
                        late_err  <= 1'b0;
                        good_run  <= 4'd0;
                        state     <= ev ? ACQUIRE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tick_period_monitor.sv
// Scoreboard bench for tick_period_monitor: two instances (TOL=0 and TOL=1) share stimulus and
// are compared each cycle against a timestamp-based reference model.
module tb_tick_period_monitor;
    logic clk_1ms = 1'b0;
    logic reset = 1'b1;
    logic tick_in = 1'b0;
    logic clear_fault = 1'b0;

    logic        locked0, fault0, early0, late0;
    logic [7:0]  pl0, mc0;
    logic [15:0] tc0;
    logic        locked1, fault1, early1, late1;
    logic [7:0]  pl1, mc1;
    logic [15:0] tc1;

    tick_period_monitor u0 (
        .clk_1ms(clk_1ms), .reset(reset), .tick_in(tick_in), .clear_fault(clear_fault),
        .locked(locked0), .fault(fault0), .early_err(early0), .late_err(late0),
        .period_last(pl0), .tick_count(tc0), .missed_count(mc0));

    tick_period_monitor #(.EXP_PERIOD(6), .TOL(1), .LOCK_COUNT(4), .CNT_W(16)) u1 (
        .clk_1ms(clk_1ms), .reset(reset), .tick_in(tick_in), .clear_fault(clear_fault),
        .locked(locked1), .fault(fault1), .early_err(early1), .late_err(late1),
        .period_last(pl1), .tick_count(tc1), .missed_count(mc1));

    always #5 clk_1ms = ~clk_1ms;

    typedef struct packed {
        logic        locked;
        logic        fault;
        logic        early;
        logic        late;
        logic [7:0]  pl;
        logic [15:0] tc;
        logic [7:0]  mc;
    } out_t;

    typedef struct packed {
        int   tgt;
        out_t e0;
        out_t e1;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk_1ms) cyc <= cyc + 1;

    // Reference model: the period is the distance in clock edges between consecutive tick
    // events (reset acts as a reference point), saturated at 255.
    localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2, M_FAULT = 3;
    int   m_mode[2];
    int   m_good[2];
    int   m_ref[2];
    bit   m_td[2];
    out_t m_out[2];
    int   lo[2] = '{6, 5};
    int   hi[2] = '{6, 7};

    task automatic model_step(input int i, input bit t, input bit c, input bit r, input int e);
        bit ev;
        int age;
        int p;
        int prev;
        if (r) begin
            m_mode[i] = M_IDLE; m_good[i] = 0; m_ref[i] = e; m_td[i] = 1'b1;
            m_out[i] = '0;
            return;
        end
        ev = t && !m_td[i];
        m_td[i] = t;
        age = e - m_ref[i];
        p = (age > 255) ? 255 : age;
        prev = m_mode[i];
        if (ev) m_out[i].tc = m_out[i].tc + 16'd1;
        if (ev && prev != M_IDLE) m_out[i].pl = 8'(p);
        case (prev)
            M_IDLE: if (ev) begin m_mode[i] = M_ACQ; m_good[i] = 0; end
            M_ACQ: begin
                if (ev) begin
                    if (p >= lo[i] && p <= hi[i]) begin
                        m_good[i]++;
                        if (m_good[i] == 4) m_mode[i] = M_LOCK;
                    end else m_good[i] = 0;
                end else if (age >= 256) m_mode[i] = M_IDLE;
            end
            M_LOCK: begin
                if (ev) begin
                    if (p < lo[i]) begin m_mode[i] = M_FAULT; m_out[i].early = 1'b1; end
                end else if (age == hi[i]) begin
                    m_mode[i] = M_FAULT; m_out[i].late = 1'b1;
                    if (m_out[i].mc != 8'hFF) m_out[i].mc = m_out[i].mc + 8'd1;
                end
            end
            default: begin
                if (c) begin
                    m_out[i].early = 1'b0; m_out[i].late = 1'b0; m_good[i] = 0;
                    m_mode[i] = ev ? M_ACQ : M_IDLE;
                end
            end
        endcase
        if (ev) m_ref[i] = e;
        m_out[i].locked = (m_mode[i] == M_LOCK);
        m_out[i].fault  = (m_mode[i] == M_FAULT);
    endtask

    // Applies inputs for the next edge, records the expected result, then advances one cycle.
    task automatic drive(input bit t, input bit c, input bit r);
        exp_t x;
        tick_in = t; clear_fault = c; reset = r;
        for (int i = 0; i < 2; i++) model_step(i, t, c, r, cyc + 1);
        x.tgt = cyc + 1; x.e0 = m_out[0]; x.e1 = m_out[1];
        q.push_back(x);
        @(posedge clk_1ms);
        #1;
    endtask

    task automatic pulse_gap(input int gap);
        drive(1'b1, 1'b0, 1'b0);
        repeat (gap - 1) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs once the edge each queued entry targets has occurred.
    always begin
        @(posedge clk_1ms);
        #3;
        while (q.size() != 0 && q[0].tgt <= cyc) begin
            exp_t x;
            out_t a0, a1;
            x = q.pop_front();
            a0 = {locked0, fault0, early0, late0, pl0, tc0, mc0};
            a1 = {locked1, fault1, early1, late1, pl1, tc1, mc1};
            total++;
            if (a0 !== x.e0) begin
                bad++;
                $display("FAIL out_tol0 edge=%0d got=%h expected=%h", x.tgt, a0, x.e0);
            end
            total++;
            if (a1 !== x.e1) begin
                bad++;
                $display("FAIL out_tol1 edge=%0d got=%h expected=%h", x.tgt, a1, x.e1);
            end
        end
    end

    initial begin
        int gap, w, cap;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE; m_good[i] = 0; m_ref[i] = 0; m_td[i] = 1'b1; m_out[i] = '0;
        end
        repeat (3) drive(1'b0, 1'b0, 1'b1);
        chk("reset_tick_count", int'(tc0), 0);
        drive(1'b0, 1'b0, 1'b0);

        // Periodic ticks: lock after the fifth pulse.
        repeat (4) pulse_gap(6);
        drive(1'b1, 1'b0, 1'b0);
        chk("lock_locked", int'(locked0), 1);
        chk("lock_period_last", int'(pl0), 6);
        chk("lock_tick_count", int'(tc0), 5);
        chk("lock_fault", int'(fault0), 0);

        // Early tick, four cycles after the previous one.
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        chk("early_fault", int'(fault0), 1);
        chk("early_err", int'(early0), 1);
        chk("early_late_err", int'(late0), 0);
        chk("early_locked", int'(locked0), 0);
        chk("early_period_last", int'(pl0), 4);
        chk("early_missed", int'(mc0), 0);

        // Clear coinciding with a tick, then relock after four more periods.
        repeat (5) drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        chk("clr_fault", int'(fault0), 0);
        chk("clr_early_err", int'(early0), 0);
        repeat (3) begin
            repeat (5) drive(1'b0, 1'b0, 1'b0);
            drive(1'b1, 1'b0, 1'b0);
        end
        chk("clr_not_yet_locked", int'(locked0), 0);
        repeat (5) drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        chk("clr_relocked", int'(locked0), 1);

        // Missing tick: fault on the edge ending the deadline cycle.
        repeat (5) drive(1'b0, 1'b0, 1'b0);
        chk("miss_before_deadline", int'(fault0), 0);
        drive(1'b0, 1'b0, 1'b0);
        chk("miss_fault", int'(fault0), 1);
        chk("miss_late_err", int'(late0), 1);
        chk("miss_early_err", int'(early0), 0);
        chk("miss_count", int'(mc0), 1);
        chk("miss_tick_count", int'(tc0), 11);
        drive(1'b0, 1'b1, 1'b0);
        chk("clear_idle_fault", int'(fault0), 0);

        // Tick held high across reset release is not an event.
        repeat (2) drive(1'b1, 1'b0, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        chk("held_tick_count", int'(tc0), 0);
        chk("held_locked", int'(locked0), 0);
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        chk("held_one_event", int'(tc0), 1);

        // TOL=1 acquisition with a rejected period of 9.
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        pulse_gap(6); pulse_gap(7); pulse_gap(9); pulse_gap(5); pulse_gap(6); pulse_gap(6);
        drive(1'b1, 1'b0, 1'b0);
        chk("tol1_not_locked", int'(locked1), 0);
        repeat (5) drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        chk("tol1_locked", int'(locked1), 1);
        chk("tol1_period_last", int'(pl1), 6);
        drive(1'b0, 1'b0, 1'b1);
        chk("reset_mid_lock_locked", int'(locked1), 0);
        chk("reset_mid_lock_count", int'(tc1), 0);

        // Randomised traffic, mostly near the nominal period with occasional long stalls.
        drive(1'b0, 1'b0, 1'b0);
        repeat (400) begin
            if ($urandom_range(0, 29) == 0) gap = 260;
            else if ($urandom_range(0, 9) < 6) gap = 6;
            else gap = $urandom_range(3, 9);
            cap = (gap > 3) ? 3 : gap - 1;
            w = $urandom_range(1, cap);
            for (int k = 0; k < gap; k++)
                drive(k < w, $urandom_range(0, 7) == 0, $urandom_range(0, 799) == 0);
        end

        repeat (3) @(posedge clk_1ms);
        #5;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tick_period_monitor.md
Name: tick_period_monitor

Overview:
- Receiving end of the clk_1ms-domain tick-pulse interface that the game's clock dividers drive.
- Watches one divider output (e.g. the 5 ms tick), measures the spacing between pulses and locks onto the expected period.
- Flags early or missing ticks and keeps tick and miss counters, so game timing logic can detect a stalled or mis-configured divider.

Parameters:
- EXP_PERIOD, 6, expected clk_1ms cycles between tick events (divider counting 0..5); legal range 2..(254-TOL).
- TOL, 0, allowed ± deviation in cycles; must be < EXP_PERIOD-1.
- LOCK_COUNT, 4, consecutive in-tolerance periods needed to assert locked; legal range 1..15.
- CNT_W, 16, width of tick_count.

Ports:
- clk_1ms  in  1  system tick clock; all state on its rising edge.
- reset  in  1  synchronous, active-high.
- tick_in  in  1  tick from divider, synchronous to clk_1ms.
- clear_fault  in  1  one-cycle request to leave FAULT.
- locked  out  1  high in LOCKED state.
- fault  out  1  high in FAULT state.
- early_err  out  1  sticky; an early tick caused the fault.
- late_err  out  1  sticky; a missing or late tick caused the fault.
- period_last  out  8  last measured period in cycles, saturating at 255.
- tick_count  out  CNT_W  tick events since reset; wraps.
- missed_count  out  8  late-tick faults since reset; saturates at 255.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk_1ms.
- Reset dominates every other input. On reset:
  - outputs: all 0; period_last=0.
  - internal: state=IDLE, gap counter cnt=0, good_run=0, tick_d=1.
  - Because tick_d=1, a tick_in held high through reset release is not an event.
- Event detection: ev = tick_in & ~tick_d, where tick_d is tick_in registered. A multi-cycle high counts once. No added latency: ev acts in the same cycle.
- Gap counter:
  - On an ev cycle, cnt_next = 0; otherwise cnt_next = cnt+1, saturating at 255.
  - Measured period P = cnt+1, saturating at 255.
  - In-tolerance means EXP_PERIOD-TOL <= P <= EXP_PERIOD+TOL.
- Counters and period_last:
  - tick_count increments on every ev, in any state.
  - period_last loads P on every ev except the first ev after IDLE.
- All outputs are registered; they update on the clock edge that ends the ev or deadline cycle.
- States:
  - IDLE
    - ev → ACQUIRE, good_run=0, no period check.
  - ACQUIRE
    - ev with P in tolerance → good_run+1; when good_run reaches LOCK_COUNT → LOCKED.
    - ev out of tolerance → good_run=0, stay in ACQUIRE.
    - cnt reaches 255 with no ev → IDLE.
  - LOCKED
    - ev with P < EXP_PERIOD-TOL → FAULT, early_err=1.
    - no ev while cnt == EXP_PERIOD+TOL-1 (deadline cycle) → FAULT, late_err=1, missed_count+1.
    - ev with P in tolerance → stay in LOCKED.
    - An ev on the deadline cycle counts as on time.
  - FAULT
    - fault=1; ticks still counted.
    - clear_fault → clears early_err and late_err; next state IDLE.
    - If ev occurs in the same cycle as clear_fault, next state is ACQUIRE with cnt=0, and that ev counts as the first tick.
    - clear_fault outside FAULT is ignored.
- Only one of early_err or late_err is ever set per fault.

Test Plan:
- Periodic stimulus, period 6: reset; tick_in pulses every 6 cycles (1 cycle high) → locked=1 the cycle after the 5th pulse; period_last=6; tick_count=5; fault=0.
- Early tick: after lock, next pulse arrives 4 cycles after the previous one → fault=1, early_err=1, late_err=0, locked=0, period_last=4, missed_count=0.
- Missing tick: after lock, stop pulses → fault=1 and late_err=1 exactly 6 cycles after the last pulse (cycle following the expected pulse); missed_count=1; tick_count frozen.
- Held-high input: tick_in held high across reset release and for 3 more cycles → tick_count=0 and state stays IDLE. Holding tick_in high for 3 cycles later counts 1 event.
- Clear with coincident tick: in FAULT, assert clear_fault on the same cycle as a pulse → early_err=late_err=0, state ACQUIRE. With further 6-cycle pulses, locked=1 after 4 more pulses.
- Acquire rejection with TOL=1: periods 6,7,9,5,6,6,6 → good_run resets at period 9; locked only after the four in-tolerance periods 5,6,6,6. Mid-LOCKED reset → all outputs 0 next cycle.
